// File: rtl/keccak_msg_feeder.sv
// Byte-stream to 32-bit word feeder for the keccak message port: packs bytes
// big-endian, pulses the core reset per message and appends the pad word.
module keccak_msg_feeder #(
  parameter int RST_CYCLES  = 1,
  parameter bit WAIT_DIGEST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  s_byte,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        k_reset,
  output logic [31:0] k_in,
  output logic        k_in_ready,
  output logic        k_is_last,
  output logic [1:0]  k_byte_num,
  input  logic        k_buffer_full,
  input  logic        k_out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_FILL, S_SEND, S_WAIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic [1:0]  c_q, c_d;
  logic [31:0] pack_q, pack_d;
  logic        pad_q, pad_d;
  logic        s_ready_q, s_ready_d;
  logic        k_reset_q, k_reset_d;
  logic [31:0] k_in_q, k_in_d;
  logic        k_in_ready_q, k_in_ready_d;
  logic        k_is_last_q, k_is_last_d;
  logic [1:0]  k_byte_num_q, k_byte_num_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    c_d          = c_q;
    pack_d       = pack_q;
    pad_d        = pad_q;
    k_in_d       = k_in_q;
    k_is_last_d  = k_is_last_q;
    k_byte_num_d = k_byte_num_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RST;
          rst_cnt_d = 4'(RST_CYCLES);
          c_d       = 2'd0;
          pack_d    = 32'd0;
          pad_d     = 1'b0;
        end
      end
      S_RST: begin
        if (rst_cnt_q <= 4'd1) state_d = S_FILL;
        else                   rst_cnt_d = rst_cnt_q - 4'd1;
      end
      S_FILL: begin
        if (s_valid && s_ready_q) begin
          for (int i = 0; i < 4; i++) begin
            if (c_q == 2'(i)) pack_d[31-8*i -: 8] = s_byte;
          end
          c_d = c_q + 2'd1;
          if (s_last || c_q == 2'd3) begin
            // A last byte that fills the word defers is_last to a trailing zero word.
            k_in_d       = pack_d;
            k_is_last_d  = s_last && (c_q != 2'd3);
            k_byte_num_d = (s_last && c_q != 2'd3) ? c_q + 2'd1 : 2'd0;
            pad_d        = s_last && (c_q == 2'd3);
            state_d      = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (k_in_ready_q && !k_buffer_full) begin
          if (pad_q) begin
            k_in_d       = 32'd0;
            k_byte_num_d = 2'd0;
            k_is_last_d  = 1'b1;
            pad_d        = 1'b0;
          end else if (k_is_last_q) begin
            state_d = WAIT_DIGEST ? S_WAIT : S_DONE;
          end else begin
            c_d     = 2'd0;
            pack_d  = 32'd0;
            state_d = S_FILL;
          end
        end
      end
      S_WAIT: begin
        if (k_out_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Handshake/status outputs are registered images of the next state.
    s_ready_d    = (state_d == S_FILL);
    k_in_ready_d = (state_d == S_SEND);
    k_reset_d    = (state_d == S_RST);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= 4'd0;
      c_q          <= 2'd0;
      pack_q       <= 32'd0;
      pad_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      k_reset_q    <= 1'b0;
      k_in_q       <= 32'd0;
      k_in_ready_q <= 1'b0;
      k_is_last_q  <= 1'b0;
      k_byte_num_q <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      c_q          <= c_d;
      pack_q       <= pack_d;
      pad_q        <= pad_d;
      s_ready_q    <= s_ready_d;
      k_reset_q    <= k_reset_d;
      k_in_q       <= k_in_d;
      k_in_ready_q <= k_in_ready_d;
      k_is_last_q  <= k_is_last_d;
      k_byte_num_q <= k_byte_num_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign k_reset    = k_reset_q;
  assign k_in       = k_in_q;
  assign k_in_ready = k_in_ready_q;
  assign k_is_last  = k_is_last_q;
  assign k_byte_num = k_byte_num_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Self-checking bench for keccak_msg_feeder: two instances (WAIT_DIGEST 1 and 0)
// run in lockstep; words are checked against a byte-list model of the packing.
module tb_keccak_msg_feeder;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0]  s_byte = 8'd0;
  logic        s_valid = 1'b0, s_last = 1'b0, k_buffer_full = 1'b0, k_out_ready = 1'b0;
  logic        s_ready, k_reset, k_in_ready, k_is_last, busy, done;
  logic [31:0] k_in;
  logic [1:0]  k_byte_num;
  logic        s_ready0, k_reset0, k_in_ready0, k_is_last0, busy0, done0;
  logic [31:0] k_in0;
  logic [1:0]  k_byte_num0;

  keccak_msg_feeder #(.RST_CYCLES(2), .WAIT_DIGEST(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .s_byte(s_byte), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .k_reset(k_reset), .k_in(k_in),
    .k_in_ready(k_in_ready), .k_is_last(k_is_last), .k_byte_num(k_byte_num),
    .k_buffer_full(k_buffer_full), .k_out_ready(k_out_ready), .busy(busy), .done(done));

  keccak_msg_feeder #(.RST_CYCLES(2), .WAIT_DIGEST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .s_byte(s_byte), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready0), .k_reset(k_reset0), .k_in(k_in0),
    .k_in_ready(k_in_ready0), .k_is_last(k_is_last0), .k_byte_num(k_byte_num0),
    .k_buffer_full(k_buffer_full), .k_out_ready(1'b0), .busy(busy0), .done(done0));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic        l;
    logic [1:0]  bn;
  } wrec_t;

  wrec_t      got_q[$];
  wrec_t      exp_q[$];
  logic [7:0] msg_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done0_cnt = 0, done0_cyc = -1, last_xfer_cyc = -1;
  int kres_cyc = 0, kres_pulses = 0;
  logic kres_prev = 1'b0;
  bit out_rdy_en = 1'b0, timeout = 1'b0, bp_stop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    k_out_ready = out_rdy_en && ($urandom_range(0, 1) == 1);
  end

  // Observe at negedge: what is visible now is what the next posedge acts on.
  always @(negedge clk) begin
    wrec_t r;
    if (k_in_ready && !k_buffer_full) begin
      r = {k_in, k_is_last, k_byte_num};
      got_q.push_back(r);
      if (k_is_last) last_xfer_cyc = cyc;
    end
    if (done) done_cnt++;
    if (done0) begin
      done0_cnt++;
      done0_cyc = cyc;
    end
    if (k_reset) kres_cyc++;
    if (k_reset && !kres_prev) kres_pulses++;
    kres_prev = k_reset;
  end

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  // Reference: n bytes -> n/4 full words, then one closing word holding the
  // n%4 leftover bytes (a zero pad word when n%4 == 0).
  task automatic build_expected();
    int n;
    wrec_t r;
    n = msg_q.size();
    exp_q.delete();
    for (int wi = 0; wi <= n / 4; wi++) begin
      r.w = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4 * wi + b < n) r.w = r.w | (32'(msg_q[4 * wi + b]) << (24 - 8 * b));
      r.l  = (wi == n / 4);
      r.bn = (wi == n / 4) ? 2'(n % 4) : 2'd0;
      exp_q.push_back(r);
    end
  endtask

  task automatic start_msg();
    got_q.delete();
    done_cnt = 0; done0_cnt = 0; done0_cyc = -1; last_xfer_cyc = -1;
    kres_cyc = 0; kres_pulses = 0; timeout = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feed(input int nfeed, input int start_at, input bit gaps);
    int t;
    for (int i = 0; i < nfeed; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_byte  = msg_q[i];
      s_last  = (i == msg_q.size() - 1);
      s_valid = 1'b1;
      if (i == start_at) start = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) timeout = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    out_rdy_en = 1'b1;
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) timeout = 1'b1;
    repeat (3) @(negedge clk);
    out_rdy_en = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({s_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num, busy, done} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got k_in=%h rdy=%b busy=%b expected all zero", k_in, k_in_ready, busy);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy0, done0, k_in_ready0, s_ready0} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy0=%b s_ready0=%b expected 0", busy0, s_ready0);
    end
  endtask

  task automatic test_fox();
    load_str("The quick brown fox jumps over the lazy dog");
    build_expected();
    start_msg();
    feed(msg_q.size(), -1, 1'b0);
    wait_done();
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL fox_timeout: got timeout expected completion"); end
    n_checks++;
    if (got_q.size() !== 11) begin
      n_fail++; $display("FAIL fox_count: got %0d words expected 11", got_q.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL fox_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (got_q[0].w !== 32'h54686520 || got_q[10] !== {32'h646F6700, 1'b1, 2'd3}) begin
        n_fail++; $display("FAIL fox_ends: got %h / %h expected 54686520 / 646f6700", got_q[0].w, got_q[10].w);
      end
    end
    n_checks++;
    if (kres_pulses !== 1 || kres_cyc !== 2) begin
      n_fail++; $display("FAIL fox_kreset: got %0d pulses %0d cycles expected 1 pulse 2 cycles", kres_pulses, kres_cyc);
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL fox_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_mult4();
    load_str("Hello, world");
    build_expected();
    start_msg();
    feed(msg_q.size(), -1, 1'b1);
    wait_done();
    n_checks++;
    if (timeout || got_q.size() !== 4) begin
      n_fail++; $display("FAIL m4_count: got %0d words timeout=%b expected 4", got_q.size(), timeout);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL m4_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (got_q[2].w !== 32'h6F726C64 || got_q[3] !== {32'd0, 1'b1, 2'd0}) begin
        n_fail++; $display("FAIL m4_pad: got %h / %h expected 6f726c64 / pad", got_q[2], got_q[3]);
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL m4_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int t, nq;
    load_str("The quick brown fox jumps over the lazy dog");
    build_expected();
    start_msg();
    fork
      feed(msg_q.size(), -1, 1'b0);
      begin
        t = 0;
        @(posedge clk); #1;
        while (!(k_in_ready && k_in == 32'h71756963) && t < 400) begin
          @(posedge clk); #1;
          t++;
        end
        k_buffer_full = 1'b1;
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (k_in !== 32'h71756963 || k_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_stable: got k_in=%h rdy=%b expected 71756963 rdy=1", k_in, k_in_ready);
          end
          @(posedge clk);
        end
        #1 k_buffer_full = 1'b0;
      end
    join
    wait_done();
    nq = 0;
    foreach (got_q[i]) if (got_q[i].w == 32'h71756963) nq++;
    n_checks++;
    if (nq !== 1) begin n_fail++; $display("FAIL bp_once: got %0d copies of quic expected 1", nq); end
    n_checks++;
    if (timeout || got_q !== exp_q) begin
      n_fail++; $display("FAIL bp_sequence: got %0d words timeout=%b expected %0d words matching", got_q.size(), timeout, exp_q.size());
    end
  endtask

  task automatic test_short();
    load_str("A");
    start_msg();
    feed(1, -1, 1'b0);
    wait_done();
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== {32'h41000000, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL short_word: got %0d words first %h expected 41000000 last bn=1", got_q.size(), got_q[0]);
    end
    n_checks++;
    if (done0_cnt !== 1 || done0_cyc !== last_xfer_cyc + 1) begin
      n_fail++; $display("FAIL short_nowait_done: got %0d pulses at %0d expected 1 at %0d", done0_cnt, done0_cyc, last_xfer_cyc + 1);
    end
    n_checks++;
    if (done_cnt !== 1 || timeout) begin n_fail++; $display("FAIL short_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_control();
    bit seen_ready;
    seen_ready = 1'b0;
    @(posedge clk); #1;
    s_byte = 8'hEE; s_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (s_ready) seen_ready = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_ready) begin n_fail++; $display("FAIL ctl_idle_ready: got s_ready=1 expected 0"); end
    load_str("control!x");
    build_expected();
    start_msg();
    feed(msg_q.size(), 1, 1'b0);
    wait_done();
    n_checks++;
    if (timeout || got_q !== exp_q) begin
      n_fail++; $display("FAIL ctl_words: got %0d words first %h expected %0d first %h", got_q.size(), got_q[0], exp_q.size(), exp_q[0]);
    end
    n_checks++;
    if (kres_pulses !== 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL ctl_restart: got %0d kreset %0d done expected 1 1", kres_pulses, done_cnt);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 24);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      build_expected();
      start_msg();
      bp_stop = 1'b0;
      fork
        begin
          feed(n, -1, 1'b1);
          wait_done();
          bp_stop = 1'b1;
        end
        begin
          while (!bp_stop) begin
            @(posedge clk); #1;
            k_buffer_full = ($urandom_range(0, 2) == 0);
          end
          k_buffer_full = 1'b0;
        end
      join
      n_checks++;
      if (timeout || got_q !== exp_q) begin
        n_fail++; $display("FAIL rand%0d_words: got %0d words expected %0d (len %0d)", it, got_q.size(), exp_q.size(), n);
      end
      n_checks++;
      if (done_cnt !== 1 || done0_cnt !== 1) begin
        n_fail++; $display("FAIL rand%0d_done: got %0d/%0d expected 1/1", it, done_cnt, done0_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    load_str("The quick brown fox");
    start_msg();
    feed(4, -1, 1'b0);
    n_checks++;
    if (k_in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_send: got rdy=%b expected 1", k_in_ready); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({s_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num, busy, done,
         k_in0, k_in_ready0, busy0} !== 74'd0) begin
      n_fail++; $display("FAIL ar_outputs: got k_in=%h rdy=%b busy=%b expected all zero", k_in, k_in_ready, busy);
    end
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ar_no_done: got done=%0d busy=%b expected 0 0", done_cnt, busy);
    end
    load_str("abcdef");
    build_expected();
    start_msg();
    feed(msg_q.size(), -1, 1'b0);
    wait_done();
    n_checks++;
    if (timeout || got_q !== exp_q || done_cnt !== 1) begin
      n_fail++; $display("FAIL ar_recover: got %0d words done=%0d expected %0d words done=1", got_q.size(), done_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fox();
    test_mult4();
    test_backpressure();
    test_short();
    test_control();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keccak_msg_feeder.md
Name: keccak_msg_feeder

Overview:
- Transmit-side driver for the keccak core's message input port.
- Takes a message as a byte stream (valid/ready) and packs bytes big-endian into 32-bit words.
- Drives in/in_ready/is_last/byte_num, honours buffer_full back-pressure and emits the zero pad word when the length is a multiple of 4.
- Pulses the core reset before each message, then waits for out_ready; it sits between any byte source (UART, DMA, bench) and the keccak instance.

Parameters:
RST_CYCLES, 1, number of cycles k_reset is held high at message start (legal 1..15)
WAIT_DIGEST, 1, 1 = hold busy until k_out_ready after the last word; 0 = finish when the last word is accepted

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle request to begin a new message; honoured only in IDLE
s_byte  input  8  message byte
s_valid  input  1  s_byte valid
s_last  input  1  s_byte is the final message byte (qualified by s_valid)
s_ready  output  1  feeder accepts s_byte this cycle
k_reset  output  1  drives keccak reset
k_in  output  32  drives keccak in
k_in_ready  output  1  drives keccak in_ready
k_is_last  output  1  drives keccak is_last
k_byte_num  output  2  drives keccak byte_num
k_buffer_full  input  1  from keccak buffer_full
k_out_ready  input  1  from keccak out_ready
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on message completion

Behaviour:
- Reset values: all outputs 0, state IDLE, pack register 0, byte counter 0, pad_pending 0.
- Byte transfer: happens on an edge with s_valid & s_ready. A word transfer happens on an edge with k_in_ready & !k_buffer_full.
- Packing: byte index c (0..3) is written to pack[31-8c -: 8], so the first byte lands in [31:24]. Unfilled lanes of a partial word are 0.
- Registered outputs: k_in, k_in_ready, k_is_last and k_byte_num are registered and held stable while k_in_ready=1 and k_buffer_full=1.
- IDLE: s_ready=0, k_in_ready=0. On start go to RST with the counter loaded to RST_CYCLES.
- RST: k_reset=1 for exactly RST_CYCLES cycles, then go to FILL.
- FILL: s_ready=1. On each byte transfer, write the lane and increment c.
  - 4th byte, s_last=0: load the word, k_is_last=0, k_byte_num=0, go to SEND.
  - s_last=1 with c<3: load the word, k_is_last=1, k_byte_num=c+1, go to SEND.
  - s_last=1 with c=3: load the full word, k_is_last=0, set pad_pending, go to SEND.
- SEND: s_ready=0, k_in_ready=1. On word transfer:
  - if pad_pending: load k_in=0, k_byte_num=0, k_is_last=1, clear pad_pending, stay in SEND;
  - else if the word just sent had k_is_last=1: go to WAIT (WAIT_DIGEST=1) or DONE (WAIT_DIGEST=0);
  - else clear c and the pack register and go to FILL.
  - k_in_ready drops the cycle after the final accepted word.
- WAIT: k_in_ready=0. When k_out_ready=1, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Minimum message length is 1 byte. A message is terminated only by s_last.
- Simultaneous events: start is ignored while busy. s_valid is ignored outside FILL. A byte with s_last=1 is the last byte accepted for the message.
- Throughput: one byte per cycle in FILL, plus at least one SEND cycle per word.
- Reset mid-operation: asynchronously returns to IDLE with all outputs 0. The partial message is discarded and no done pulse is produced.

Test Plan:
- Full/partial words: start; 43 bytes "The quick brown fox jumps over the lazy dog", s_last on 'g', no stall -> one k_reset pulse, then 10 words with is_last=0 (first k_in=0x54686520), then k_in=0x646F6700, byte_num=3, is_last=1. After forcing k_out_ready, exactly one done pulse.
- Multiple-of-4 length: 12 bytes "Hello, world" -> 3 words 0x48656C6C, 0x6F2C2077, 0x6F726C64 (all is_last=0), then pad word k_in=0, byte_num=0, is_last=1.
- Back-pressure: hold k_buffer_full=1 for 5 cycles during SEND of the word "quic" -> k_in=0x71756963 and k_in_ready stay stable; the word is transferred once on the first edge with buffer_full=0, with no duplicate or lost word.
- Short message: 1 byte 'A' with s_last -> single word 0x41000000, byte_num=1, is_last=1. With WAIT_DIGEST=0, done follows acceptance by 1 cycle with no k_out_ready.
- Control: start pulsed again during FILL is ignored. s_valid asserted in IDLE is not consumed (s_ready=0).
- Async reset: assert reset mid-SEND -> all outputs 0 immediately with no clock edge. A following start/message completes normally.
